// File: rtl/lvda_proc_data_shifter.sv
// LVDA process-data shifter: deserialises one LVDC word, latches group bits 1-7 and
// sequences the V1/Y4/Z4/Y6/LTRV write window. Define LVDA_PARITY_EN for the odd-parity bit.
module lvda_proc_data_shifter #(
    parameter int unsigned WORD_BITS = 26,
    parameter int unsigned HOLD_CYC  = 8
) (
    input  logic SIM_CLK,
    input  logic SIM_RST,
    input  logic WSTRT,
    input  logic LTR,
    input  logic SBIT,
    input  logic SBEN,
    output logic G1DV,
    output logic G2DV,
    output logic G3DV,
    output logic G4DV,
    output logic G5DV,
    output logic G6DV,
    output logic G7DV,
    output logic G1DVN,
    output logic G2DVN,
    output logic G3DVN,
    output logic G4DVN,
    output logic G5DVN,
    output logic G6DVN,
    output logic G7DVN,
    output logic V1,
    output logic Y4,
    output logic Z4,
    output logic Y6,
    output logic LTRV,
    output logic BUSY,
    output logic OVR
`ifdef LVDA_PARITY_EN
    ,
    output logic PERR
`endif
);

`ifdef LVDA_PARITY_EN
    localparam int unsigned NBITS = WORD_BITS + 1;
`else
    localparam int unsigned NBITS = WORD_BITS;
`endif
    localparam int unsigned BCW = $clog2(NBITS);
    localparam int unsigned HCW = $clog2(HOLD_CYC);

    typedef enum logic [1:0] {StIdle, StShift, StHold} state_e;

    state_e         state_q, state_d;
    logic [BCW-1:0] bit_cnt_q, bit_cnt_d;
    logic [HCW-1:0] hold_cnt_q, hold_cnt_d;
    logic [6:0]     stage_q, stage_d;
    logic [6:0]     gdv_q, gdv_d;
    logic [6:0]     gdvn_q, gdvn_d;
    logic           ltr_q, ltr_d;
    logic           ovr_q, ovr_d;
    logic           v1_q, v1_d;
    logic           y4_q, y4_d;
    logic           z4_q, z4_d;
    logic           y6_q, y6_d;
    logic           ltrv_q, ltrv_d;
    logic           busy_q, busy_d;
    logic           word_ok;
    logic           win_ok;
`ifdef LVDA_PARITY_EN
    logic           par_q, par_d;
    logic           good_q, good_d;
    logic           perr_q, perr_d;
`endif

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        hold_cnt_d = hold_cnt_q;
        stage_d    = stage_q;
        gdv_d      = gdv_q;
        gdvn_d     = gdvn_q;
        ltr_d      = ltr_q;
        ovr_d      = ovr_q;
        word_ok    = 1'b1;
`ifdef LVDA_PARITY_EN
        par_d      = par_q;
        good_d     = good_q;
        perr_d     = perr_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (WSTRT) begin
                    state_d   = StShift;
                    bit_cnt_d = '0;
                    ltr_d     = LTR;
`ifdef LVDA_PARITY_EN
                    par_d     = 1'b0;
`endif
                end
            end
            StShift: begin
                if (WSTRT) ovr_d = 1'b1;
                if (SBEN) begin
                    for (int i = 0; i < 7; i++) begin
                        if (bit_cnt_q == BCW'(i)) stage_d[i] = SBIT;
                    end
`ifdef LVDA_PARITY_EN
                    par_d = par_q ^ SBIT;
`endif
                    if (bit_cnt_q == BCW'(NBITS - 1)) begin
                        state_d    = StHold;
                        hold_cnt_d = '0;
`ifdef LVDA_PARITY_EN
                        // Odd parity: XOR over every bit including parity must be 1.
                        word_ok = par_d;
                        good_d  = par_d;
                        perr_d  = perr_q | ~par_d;
`endif
                        if (word_ok) begin
                            gdv_d  = stage_d;
                            gdvn_d = ~stage_d;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + BCW'(1);
                    end
                end
            end
            StHold: begin
                if (WSTRT) ovr_d = 1'b1;
                if (hold_cnt_q == HCW'(HOLD_CYC - 1)) begin
                    state_d = StIdle;
                end else begin
                    hold_cnt_d = hold_cnt_q + HCW'(1);
                end
            end
            default: state_d = StIdle;
        endcase

`ifdef LVDA_PARITY_EN
        win_ok = good_d;
`else
        win_ok = 1'b1;
`endif
        // Outputs are computed from next state so every output comes straight off a flop.
        v1_d   = (state_d == StHold) && win_ok;
        y4_d   = v1_d && (hold_cnt_d == HCW'(3));
        z4_d   = v1_d && (hold_cnt_d == HCW'(4));
        y6_d   = v1_d && (hold_cnt_d == HCW'(5));
        ltrv_d = v1_d && ltr_d;
        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge SIM_CLK) begin
        if (SIM_RST) begin
            state_q    <= StIdle;
            bit_cnt_q  <= '0;
            hold_cnt_q <= '0;
            stage_q    <= '0;
            gdv_q      <= '0;
            gdvn_q     <= '1;
            ltr_q      <= 1'b0;
            ovr_q      <= 1'b0;
            v1_q       <= 1'b0;
            y4_q       <= 1'b0;
            z4_q       <= 1'b0;
            y6_q       <= 1'b0;
            ltrv_q     <= 1'b0;
            busy_q     <= 1'b0;
`ifdef LVDA_PARITY_EN
            par_q      <= 1'b0;
            good_q     <= 1'b0;
            perr_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            hold_cnt_q <= hold_cnt_d;
            stage_q    <= stage_d;
            gdv_q      <= gdv_d;
            gdvn_q     <= gdvn_d;
            ltr_q      <= ltr_d;
            ovr_q      <= ovr_d;
            v1_q       <= v1_d;
            y4_q       <= y4_d;
            z4_q       <= z4_d;
            y6_q       <= y6_d;
            ltrv_q     <= ltrv_d;
            busy_q     <= busy_d;
`ifdef LVDA_PARITY_EN
            par_q      <= par_d;
            good_q     <= good_d;
            perr_q     <= perr_d;
`endif
        end
    end

    assign G1DV  = gdv_q[0];
    assign G2DV  = gdv_q[1];
    assign G3DV  = gdv_q[2];
    assign G4DV  = gdv_q[3];
    assign G5DV  = gdv_q[4];
    assign G6DV  = gdv_q[5];
    assign G7DV  = gdv_q[6];
    assign G1DVN = gdvn_q[0];
    assign G2DVN = gdvn_q[1];
    assign G3DVN = gdvn_q[2];
    assign G4DVN = gdvn_q[3];
    assign G5DVN = gdvn_q[4];
    assign G6DVN = gdvn_q[5];
    assign G7DVN = gdvn_q[6];
    assign V1    = v1_q;
    assign Y4    = y4_q;
    assign Z4    = z4_q;
    assign Y6    = y6_q;
    assign LTRV  = ltrv_q;
    assign BUSY  = busy_q;
    assign OVR   = ovr_q;
`ifdef LVDA_PARITY_EN
    assign PERR  = perr_q;
`endif

endmodule
